alu_cmd_sequencer: RTL

- Front-end/back-end wrapper for the team's start/ready-pulse ALU.
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Issues one operation at a time to the ALU (single-cycle start pulse), then captures the result on the ALU ready pulse.
- Returns result plus complete, self-consistent flags over a valid/ready response stream.

---
 rtl/alu_cmd_sequencer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + single-outstanding issue FSM in front of a start/ready-pulse ALU.
// Define ALU_SEQ_TIMEOUT_EN to force an error response when the ALU never answers.
module alu_cmd_sequencer #(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_opcode,
    input  logic [N-1:0]             cmd_a,
    input  logic [N-1:0]             cmd_b,
    output logic                     alu_start,
    output logic [3:0]               alu_opcode,
    output logic [N-1:0]             alu_a,
    output logic [N-1:0]             alu_b,
    input  logic                     alu_ready,
    input  logic [2*N-1:0]           alu_result,
    input  logic                     alu_c,
    input  logic                     alu_v,
    input  logic                     alu_e,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [2*N-1:0]           rsp_result,
    output logic                     rsp_z,
    output logic                     rsp_c,
    output logic                     rsp_v,
    output logic                     rsp_s,
    output logic                     rsp_e,
    output logic                     rsp_timeout,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 + 2 * N;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      mem_d [DEPTH];
    logic [3:0]         op_q, op_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [2*N-1:0]     rsp_result_q, rsp_result_d;
    logic               rsp_z_q, rsp_z_d;
    logic               rsp_c_q, rsp_c_d;
    logic               rsp_v_q, rsp_v_d;
    logic               rsp_s_q, rsp_s_d;
    logic               rsp_e_q, rsp_e_d;
    logic               push;
    logic               pop;
    logic               fifo_empty;

    assign cmd_ready  = (count_q != FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = cmd_valid && cmd_ready;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               tmo_hit;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // alu_ready is tested before tmo_hit in the FSM, so a same-cycle answer wins.
    assign tmo_hit     = (state_q == WAIT) && (tmo_cnt_d == TW'(TIMEOUT));
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
`else
    logic tmo_unused;
    assign tmo_unused  = (TIMEOUT > 0);
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_z_d      = rsp_z_q;
        rsp_c_d      = rsp_c_q;
        rsp_v_d      = rsp_v_q;
        rsp_s_d      = rsp_s_q;
        rsp_e_d      = rsp_e_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
`endif
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_ready) begin
                    rsp_result_d = alu_result;
                    rsp_z_d      = (alu_result == '0);
                    rsp_s_d      = alu_result[2*N-1];
                    rsp_c_d      = alu_c;
                    rsp_v_d      = alu_v;
                    rsp_e_d      = alu_e;
                    rsp_valid_d  = 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    state_d      = DONE;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (tmo_hit) begin
                    rsp_result_d  = '0;
                    rsp_z_d       = 1'b1;
                    rsp_s_d       = 1'b0;
                    rsp_c_d       = 1'b0;
                    rsp_v_d       = 1'b0;
                    rsp_e_d       = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = DONE;
                end
`endif
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (pop) begin
            {op_d, a_d, b_d} = mem_q[rd_ptr_q];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_opcode, cmd_a, cmd_b};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_q        <= '{default: '0};
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_z_q      <= 1'b0;
            rsp_c_q      <= 1'b0;
            rsp_v_q      <= 1'b0;
            rsp_s_q      <= 1'b0;
            rsp_e_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_z_q      <= rsp_z_d;
            rsp_c_q      <= rsp_c_d;
            rsp_v_q      <= rsp_v_d;
            rsp_s_q      <= rsp_s_d;
            rsp_e_q      <= rsp_e_d;
        end
    end

    assign alu_start  = (state_q == ISSUE);
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_z      = rsp_z_q;
    assign rsp_c      = rsp_c_q;
    assign rsp_v      = rsp_v_q;
    assign rsp_s      = rsp_s_q;
    assign rsp_e      = rsp_e_q;
    assign fifo_count = count_q;

endmodule
